// File: rtl/sc_hit_arbiter.sv
// Round-robin arbiter feeding per-lane hit timing into the shared scorer.
// Ports: clk/reset_n/clear, hit_valid/hit_dt/hit_ready, miss, sc_en/sc_dt/sc_lane, combo/max_combo/mult, busy.
module sc_hit_arbiter #(
  parameter int LANES  = 5,
  parameter int DT_W   = 16,
  parameter int WINDOW = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [LANES-1:0]      hit_valid,
  input  logic [LANES*DT_W-1:0] hit_dt,
  output logic [LANES-1:0]      hit_ready,
  input  logic [LANES-1:0]      miss,
  output logic                  sc_en,
  output logic [DT_W-1:0]       sc_dt,
  output logic [2:0]            sc_lane,
  output logic [15:0]           combo,
  output logic [15:0]           max_combo,
  output logic [2:0]            mult,
  output logic                  busy
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0] pend;
  logic [LANES-1:0] grant;
  logic [LANES-1:0] acc;
  logic [DT_W-1:0]  dt_q [LANES];
  logic [PW-1:0]    rr;
  logic [PW-1:0]    gidx;
  logic             gv;
  logic             late;
  logic [15:0]      combo_n;
  logic [15:0]      max_n;

  // First pending lane at or after rr, wrapping.
  always_comb begin
    logic [PW:0] sum;
    grant = '0;
    gv    = 1'b0;
    gidx  = '0;
    sum   = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = {1'b0, rr} + (PW+1)'(k);
      if (sum >= (PW+1)'(LANES))
        sum = sum - (PW+1)'(LANES);
      if (!gv && !clear && pend[sum[PW-1:0]]) begin
        gv   = 1'b1;
        gidx = sum[PW-1:0];
      end
    end
    if (gv)
      grant[gidx] = 1'b1;
  end

  // Granted lane frees its slot this cycle, so it may refill.
  assign hit_ready = (~pend | grant) & {LANES{~clear}};
  assign acc       = hit_valid & hit_ready;
  assign busy      = |pend;
  assign late      = gv && (dt_q[gidx] >= DT_W'(WINDOW));

  // A miss anywhere breaks the streak even over a good grant.
  always_comb begin
    combo_n = combo;
    if (|miss)
      combo_n = '0;
    else if (late)
      combo_n = '0;
    else if (gv && combo != 16'hFFFF)
      combo_n = combo + 16'd1;
    max_n = (combo_n > max_combo) ? combo_n : max_combo;
  end

  always_comb begin
    if (combo < 16'd10)
      mult = 3'd1;
    else if (combo < 16'd20)
      mult = 3'd2;
    else if (combo < 16'd30)
      mult = 3'd3;
    else
      mult = 3'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= '0;
      rr        <= '0;
      sc_en     <= 1'b0;
      sc_dt     <= '0;
      sc_lane   <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else if (clear) begin
      pend      <= '0;
      rr        <= '0;
      sc_en     <= 1'b0;
      sc_dt     <= '0;
      sc_lane   <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      pend      <= (pend & ~grant) | acc;
      sc_en     <= gv;
      combo     <= combo_n;
      max_combo <= max_n;
      if (gv) begin
        sc_dt   <= dt_q[gidx];
        sc_lane <= 3'(gidx);
        if (gidx == PW'(LANES-1))
          rr <= '0;
        else
          rr <= gidx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++)
        dt_q[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (acc[i])
          dt_q[i] <= hit_dt[i*DT_W +: DT_W];
    end
  end

endmodule

// File: tb/tb_sc_hit_arbiter.sv
// Randomized scoreboard bench for sc_hit_arbiter.
// Stimulus drives lanes at negedge; a monitor checks scorer events after posedge.
module tb_sc_hit_arbiter;

  localparam int L   = 5;
  localparam int W   = 16;
  localparam int WIN = 100;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear = 1'b0;
  logic [L-1:0]   hit_valid = '0;
  logic [L*W-1:0] hit_dt = '0;
  logic [L-1:0]   hit_ready;
  logic [L-1:0]   miss = '0;
  logic           sc_en;
  logic [W-1:0]   sc_dt;
  logic [2:0]     sc_lane;
  logic [15:0]    combo;
  logic [15:0]    max_combo;
  logic [2:0]     mult;
  logic           busy;

  sc_hit_arbiter #(.LANES(L), .DT_W(W), .WINDOW(WIN)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .hit_valid(hit_valid), .hit_dt(hit_dt), .hit_ready(hit_ready),
    .miss(miss), .sc_en(sc_en), .sc_dt(sc_dt), .sc_lane(sc_lane),
    .combo(combo), .max_combo(max_combo), .mult(mult), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int lane;
    int dt;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  // Reference state: what the block should hold after the last edge.
  bit  mpend[L];
  int  mdt[L];
  int  mrr = 0;
  int  mcombo = 0;
  int  mmax = 0;
  // Lane drivers: a lane holds its hit until the model says accepted.
  bit  tv[L];
  int  tdt[L];

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_mult(int c);
    if (c < 10) return 1;
    if (c < 20) return 2;
    if (c < 30) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      mpend[i] = 0;
      mdt[i] = 0;
    end
    mrr = 0;
    mcombo = 0;
    mmax = 0;
  endtask

  always @(posedge clk) begin
    ev_t e;
    cyc++;
    #1;
    if (q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      chk("sc_en", sc_en, 1);
      chk("sc_lane", sc_lane, e.lane);
      chk("sc_dt", sc_dt, e.dt);
    end else begin
      chk("sc_en_idle", sc_en, 0);
    end
  end

  task automatic check_state();
    chk("combo", combo, mcombo);
    chk("max_combo", max_combo, mmax);
    chk("mult", mult, exp_mult(mcombo));
  endtask

  // Drive this cycle's inputs and predict the effect of the next edge.
  task automatic apply(logic [L-1:0] ms);
    int g;
    int nc;
    bit any;
    logic [L-1:0] rdy;
    ev_t e;
    for (int i = 0; i < L; i++) begin
      hit_valid[i] = tv[i];
      hit_dt[i*W +: W] = W'(tdt[i]);
    end
    miss = ms;
    #1;
    g = -1;
    any = 0;
    rdy = '0;
    for (int i = 0; i < L; i++)
      if (mpend[i]) any = 1;
    if (!clear) begin
      for (int k = 0; k < L; k++) begin
        int idx = (mrr + k) % L;
        if (g < 0 && mpend[idx]) g = idx;
      end
      for (int i = 0; i < L; i++)
        rdy[i] = !mpend[i] || (i == g);
    end
    chk("hit_ready", hit_ready, rdy);
    chk("busy", busy, any);
    if (clear) begin
      model_reset();
    end else begin
      nc = mcombo;
      if (g >= 0) begin
        e.tag = cyc + 1;
        e.lane = g;
        e.dt = mdt[g];
        q.push_back(e);
        if (mdt[g] >= WIN) nc = 0;
        else if (mcombo < 65535) nc = mcombo + 1;
        mrr = (g + 1) % L;
        mpend[g] = 0;
      end
      if (ms != '0) nc = 0;
      mcombo = nc;
      if (nc > mmax) mmax = nc;
      for (int i = 0; i < L; i++)
        if (tv[i] && rdy[i]) begin
          mpend[i] = 1;
          mdt[i] = tdt[i];
          tv[i] = 0;
        end
    end
  endtask

  task automatic step(int pv, int plate, int pmiss,
                      logic [L-1:0] fms = '0);
    logic [L-1:0] ms;
    @(negedge clk);
    clear = 1'b0;
    check_state();
    ms = fms;
    for (int i = 0; i < L; i++) begin
      if (!tv[i] && $urandom_range(99) < pv) begin
        tv[i] = 1;
        if ($urandom_range(99) < plate)
          tdt[i] = $urandom_range(4000, WIN);
        else
          tdt[i] = $urandom_range(WIN - 1, 0);
      end
      if ($urandom_range(99) < pmiss) ms[i] = 1'b1;
    end
    apply(ms);
  endtask

  task automatic clear_cycle();
    @(negedge clk);
    check_state();
    clear = 1'b1;
    apply('0);
  endtask

  task automatic fill_all();
    for (int i = 0; i < L; i++) begin
      tv[i] = 1;
      tdt[i] = $urandom_range(200, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < L; i++) begin
      tv[i] = 0;
      tdt[i] = 0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sc_en", sc_en, 0);
    chk("rst_sc_dt", sc_dt, 0);
    chk("rst_sc_lane", sc_lane, 0);
    chk("rst_busy", busy, 0);
    check_state();
    reset_n = 1'b1;

    // Contention from rr=0: lanes 0, 1, 4.
    tv[0] = 1; tdt[0] = 3;
    tv[1] = 1; tdt[1] = 30;
    tv[4] = 1; tdt[4] = 60;
    repeat (5) step(0, 0, 0);

    // Single hit on lane 2.
    tv[2] = 1; tdt[2] = 7;
    repeat (4) step(0, 0, 0);

    // Back-to-back refills on lane 3.
    for (int n = 0; n < 4; n++) begin
      tv[3] = 1;
      tdt[3] = 10 + n;
      step(0, 0, 0);
    end
    repeat (3) step(0, 0, 0);

    // Streak of 25 then a late hit.
    clear_cycle();
    for (int n = 0; n < 25; n++) begin
      tv[0] = 1;
      tdt[0] = 5;
      step(0, 0, 0);
    end
    repeat (2) step(0, 0, 0);
    tv[0] = 1; tdt[0] = 150;
    repeat (3) step(0, 0, 0);

    // Miss coincident with a good grant.
    tv[0] = 1; tdt[0] = 4;
    step(0, 0, 0);
    step(0, 0, 0, 5'b00010);
    repeat (2) step(0, 0, 0);

    // Long clean streak to reach the top multiplier.
    repeat (100) step(60, 0, 0);
    repeat (200) step(50, 20, 3);

    // Async reset between edges with everything pending.
    fill_all();
    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    check_state();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sc_en", sc_en, 0);
    chk("arst_combo", combo, 0);
    chk("arst_max", max_combo, 0);
    q.delete();
    model_reset();
    for (int i = 0; i < L; i++) tv[i] = 0;
    hit_valid = '0;
    miss = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) step(0, 0, 0);

    // Synchronous clear with everything pending.
    repeat (20) step(70, 0, 0);
    fill_all();
    step(0, 0, 0);
    step(0, 0, 0);
    clear_cycle();
    for (int i = 0; i < L; i++) tv[i] = 0;
    repeat (6) step(0, 0, 0);

    repeat (300) step(40, 15, 2);
    repeat (12) step(0, 0, 0);
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
